seq_det_sched: RTL and testbench

Time-multiplexed scheduler sharing one serial sequence-detector datapath among `N_CH` independent bit-serial channels. A round-robin arbiter grants one pending channel per cycle. The granted bit passes through a single combinational detector core, using that channel's saved 2-bit state, and the next state is written back to a per-channel state table. It sits between the serial front-ends and the event logger; each front-end sees a private detector.

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_det_core.sv | 47 ++++
 rtl/seq_det_sched.sv | 133 +++++++++++++
 tb/tb_seq_det_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial sequence detector.
// Holds the 2-bit detector state type and its four state encodings.
// Imported by the detector core and by the time-multiplexed scheduler.
package seq_det_pkg;

  typedef logic [1:0] det_state_t;

  localparam det_state_t S0 = 2'b00;
  localparam det_state_t S1 = 2'b01;
  localparam det_state_t S2 = 2'b10;
  localparam det_state_t S3 = 2'b11;

endpackage

// File: rtl/seq_det_core.sv
// Combinational sequence-detector step: (state, x) -> (next state, y).
// Latency: none, purely combinational, no clock and no storage.
// Backpressure: not applicable; the caller owns all state.
//
// Ports:
//   state : current detector state of the channel being served
//   x     : serial input bit for this step
//   ns    : next detector state to write back
//   y     : detector output for this bit
module seq_det_core
  import seq_det_pkg::*;
(
  input  det_state_t state,
  input  logic       x,
  output det_state_t ns,
  output logic       y
);

  always_comb begin
    ns = S0;
    y  = 1'b0;
    case (state)
      S0: begin
        ns = x ? S1 : S0;
        y  = 1'b0;
      end
      S1: begin
        ns = x ? S2 : S3;
        y  = x;
      end
      S2: begin
        // Output stays high on either bit; a 0 moves to S3.
        ns = x ? S2 : S3;
        y  = 1'b1;
      end
      S3: begin
        ns = x ? S1 : S0;
        y  = x;
      end
      default: begin
        ns = S0;
        y  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_det_sched.sv
// Shares one sequence-detector core among N_CH bit-serial channels.
// Latency: one cycle from gnt to out_valid/out_ch/out_y.
// Backpressure: requesters hold req/bits until their gnt; one grant per cycle.
//
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   req       : per-channel bit-valid request
//   bits      : per-channel serial bit, consumed when the channel is granted
//   clr       : per-channel state clear; blocks the grant for that cycle
//   gnt       : one-hot combinational grant, zero while rst is high
//   out_valid : registered result valid
//   out_ch    : channel index of the result (held when idle)
//   out_y     : detector output for the granted bit (held when idle)
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] bits,
  input  logic [N_CH-1:0] clr,
  output logic [N_CH-1:0] gnt,
  output logic            out_valid,
  output logic [CH_W-1:0] out_ch,
  output logic            out_y
);

  // Per-channel detector state table and round-robin pointer.
  det_state_t      st [N_CH];
  logic [CH_W-1:0] ptr;

  // Arbitration results.
  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] rot;
  logic            found;
  logic [CH_W-1:0] off;
  logic [CH_W:0]   sum;
  logic [CH_W-1:0] sel;
  logic [CH_W-1:0] ptr_next;

  // Shared detector datapath.
  det_state_t      core_state;
  logic            core_x;
  det_state_t      core_ns;
  logic            core_y;

  // A channel being cleared this cycle must not be served.
  assign elig = req & ~clr;

  // Rotate the eligible set so that bit 0 is the channel at ptr; the first
  // set bit of the rotated vector is then the round-robin winner's offset.
  always_comb begin
    rot   = N_CH'({elig, elig} >> ptr);
    found = 1'b0;
    off   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = CH_W'(i);
      end
    end
  end

  // Convert the offset back to an absolute channel index, modulo N_CH.
  // The extra bit in sum keeps ptr + off from overflowing for any N_CH.
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    sel = '0;
    if (sum >= (CH_W+1)'(N_CH)) begin
      sel = CH_W'(sum - (CH_W+1)'(N_CH));
    end else begin
      sel = CH_W'(sum);
    end
  end

  always_comb begin
    ptr_next = '0;
    if (sel != CH_W'(N_CH - 1)) begin
      ptr_next = sel + CH_W'(1);
    end
  end

  always_comb begin
    gnt = '0;
    if (found && !rst) begin
      gnt[sel] = 1'b1;
    end
  end

  assign core_state = st[sel];
  assign core_x     = bits[sel];

  seq_det_core u_core (
    .state (core_state),
    .x     (core_x),
    .ns    (core_ns),
    .y     (core_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        st[i] <= S0;
      end
      ptr       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_y     <= 1'b0;
    end else begin
      // A cleared channel is never granted, so clear and write-back
      // cannot target the same entry in one cycle.
      for (int i = 0; i < N_CH; i++) begin
        if (clr[i]) begin
          st[i] <= S0;
        end else if (gnt[i]) begin
          st[i] <= core_ns;
        end
      end
      if (found) begin
        ptr       <= ptr_next;
        out_valid <= 1'b1;
        out_ch    <= sel;
        out_y     <= core_y;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched with a table-driven reference model.
// Inputs change on the falling edge; gnt and registered outputs are sampled
// between edges and compared against the model every cycle.
module tb_seq_det_sched;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] bits;
  logic [N-1:0] clr;
  logic [N-1:0] gnt;
  logic         out_valid;
  logic [1:0]   out_ch;
  logic         out_y;

  seq_det_sched #(.N_CH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bits      (bits),
    .clr       (clr),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_y     (out_y)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: detector as lookup tables, arbiter as a modular scan.
  int ns_tab [4][2] = '{'{0, 1}, '{3, 2}, '{3, 2}, '{0, 1}};
  int y_tab  [4][2] = '{'{0, 0}, '{0, 1}, '{1, 1}, '{0, 1}};
  int m_st [N];
  int m_ptr, m_ov, m_och, m_oy;

  // Observations from the most recent cycle, plus result logs.
  logic [N-1:0] obs_gnt;
  int           obs_valid, obs_ch, obs_y;
  int           res_y [N][$];
  int           glog [$];
  int           sq [N][$];

  task automatic clear_logs();
    for (int i = 0; i < N; i++) res_y[i].delete();
    glog.delete();
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] bv,
                      input logic [N-1:0] cl, input logic rs);
    int k;
    int exp_g;
    int yv;
    int nsv;
    @(negedge clk);
    req = r; bits = bv; clr = cl; rst = rs;
    #1;
    k = -1;
    if (!rs) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (k < 0 && r[c] && !cl[c]) k = c;
      end
    end
    exp_g = (k >= 0) ? (1 << k) : 0;
    obs_gnt = gnt;
    check("gnt", int'(gnt), exp_g);
    @(posedge clk);
    #1;
    if (rs) begin
      for (int i = 0; i < N; i++) m_st[i] = 0;
      m_ptr = 0; m_ov = 0; m_och = 0; m_oy = 0;
    end else begin
      for (int i = 0; i < N; i++) if (cl[i]) m_st[i] = 0;
      if (k >= 0) begin
        yv  = y_tab[m_st[k]][bv[k]];
        nsv = ns_tab[m_st[k]][bv[k]];
        m_st[k] = nsv;
        m_ov = 1; m_och = k; m_oy = yv;
        m_ptr = (k + 1) % N;
      end else begin
        m_ov = 0;
      end
    end
    obs_valid = int'(out_valid);
    obs_ch    = int'(out_ch);
    obs_y     = int'(out_y);
    check("out_valid", obs_valid, m_ov);
    check("out_ch", obs_ch, m_och);
    check("out_y", obs_y, m_oy);
    if (out_valid) begin
      res_y[out_ch].push_back(obs_y);
      glog.push_back(obs_ch);
    end
  endtask

  task automatic do_reset();
    step('0, '0, '0, 1'b1);
    clear_logs();
  endtask

  // Each channel drains its bit queue, holding req/bits until granted.
  task automatic run_streams(input int budget);
    int n;
    int left;
    logic [N-1:0] r, bv;
    n = 0;
    left = 0;
    for (int i = 0; i < N; i++) left += sq[i].size();
    while (left > 0 && n < budget) begin
      r = '0; bv = '0;
      for (int i = 0; i < N; i++) begin
        if (sq[i].size() > 0) begin
          r[i]  = 1'b1;
          bv[i] = sq[i][0][0];
        end
      end
      step(r, bv, '0, 1'b0);
      for (int i = 0; i < N; i++) if (obs_gnt[i] && sq[i].size() > 0) void'(sq[i].pop_front());
      n++;
      left = 0;
      for (int i = 0; i < N; i++) left += sq[i].size();
    end
    check("stream_left", left, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_y6 [6] = '{0, 1, 1, 1, 0, 0};
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    int cnt [N];
    int last [N];
    int maxgap;
    logic [N-1:0] pend, pbit, r, bv, cl;
    logic rs;

    req = '0; bits = '0; clr = '0; rst = 1'b1;
    for (int i = 0; i < N; i++) m_st[i] = 0;
    m_ptr = 0; m_ov = 0; m_och = 0; m_oy = 0;

    // Reset state.
    do_reset();
    do_reset();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_out_y", int'(out_y), 0);

    // Single channel 0 with a fixed bit pattern.
    sq[0] = '{1, 1, 0, 1, 0, 0};
    run_streams(20);
    check("single_len", res_y[0].size(), 6);
    for (int i = 0; i < 6; i++) check("single_y", res_y[0][i], exp_y6[i]);
    foreach (glog[i]) check("single_ch", glog[i], 0);
    // Channel 0 should be back in S0: a 1 gives y=0.
    clear_logs();
    sq[0] = '{1};
    run_streams(4);
    check("single_final_s0", res_y[0][0], 0);

    // All channels from reset: grants 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) begin
      sq[i].push_back($urandom_range(0, 1));
      sq[i].push_back($urandom_range(0, 1));
    end
    run_streams(20);
    check("order_len", glog.size(), 8);
    for (int i = 0; i < 5; i++) check("order", glog[i], exp_ord[i]);

    // Interleaving of ch1 (1,1) and ch2 (0,1).
    do_reset();
    sq[1] = '{1, 1};
    sq[2] = '{0, 1};
    run_streams(10);
    check("ilv_ch1_y2", res_y[1][1], 1);
    check("ilv_ch2_y2", res_y[2][1], 0);
    check("ilv_g0", glog[0], 1);
    check("ilv_g1", glog[1], 2);
    check("ilv_g2", glog[2], 1);
    check("ilv_g3", glog[3], 2);

    // Clear collides with a request on the same channel.
    do_reset();
    sq[0] = '{1, 1};
    run_streams(6);
    step(4'b0001, 4'b0000, 4'b0001, 1'b0);
    check("clr_no_gnt", int'(obs_gnt[0]), 0);
    step(4'b0001, 4'b0001, 4'b0000, 1'b0);
    check("clr_then_y", obs_y, 0);
    check("clr_then_valid", obs_valid, 1);
    // From S1, a 1 must give y=1 if the state really is S1.
    step(4'b0001, 4'b0001, 4'b0000, 1'b0);
    check("clr_state_s1", obs_y, 1);

    // Reset while ch3 sits in S3 and requests.
    do_reset();
    sq[3] = '{1, 0};
    run_streams(6);
    step(4'b1000, 4'b1000, 4'b0000, 1'b1);
    check("mrst_gnt", int'(obs_gnt), 0);
    check("mrst_valid", obs_valid, 0);
    step(4'b1000, 4'b1000, 4'b0000, 1'b0);
    check("mrst_y", obs_y, 0);
    check("mrst_ch", obs_ch, 3);

    // Fairness over 64 cycles of full load.
    do_reset();
    for (int i = 0; i < N; i++) begin cnt[i] = 0; last[i] = -1; end
    maxgap = 0;
    for (int t = 0; t < 64; t++) begin
      step('1, N'($urandom), '0, 1'b0);
      for (int i = 0; i < N; i++) begin
        if (obs_gnt[i]) begin
          cnt[i]++;
          if (t - last[i] > maxgap) maxgap = t - last[i];
          last[i] = t;
        end
      end
    end
    for (int i = 0; i < N; i++) check("fair_cnt", cnt[i], 16);
    check("fair_maxgap", maxgap, 4);

    // Randomized traffic honouring the hold-until-granted handshake.
    do_reset();
    pend = '0; pbit = '0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          pbit[i] = 1'($urandom_range(0, 1));
        end
      end
      cl = '0;
      for (int i = 0; i < N; i++) cl[i] = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 63) == 0);
      r = pend; bv = pbit;
      step(r, bv, cl, rs);
      for (int i = 0; i < N; i++) if (obs_gnt[i]) pend[i] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
